// File: rtl/pdm_sampler_if.sv
// Sample stream from pdm_sampler to the decimator: one PDM bit per valid cycle,
// tagged with its channel index.
interface pdm_sampler_if;
    logic       data;
    logic       data_valid;
    logic [1:0] ch;

    modport master (output data, data_valid, ch);
    modport slave  (input  data, data_valid, ch);
endinterface

// File: rtl/pdm_sampler.sv
// Generates the PDM microphone clock, samples two stereo data lines on both
// clock phases and streams up to four channel bits per frame.
// Define PDM_SAMPLER_SYNC_EN for a 2-flop input synchronizer (default: 1 flop).
module pdm_sampler #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             cfg_en_i,
    input  logic [DIV_W-1:0] cfg_clkdiv_i,
    input  logic [1:0]       cfg_ch_num_i,
    input  logic [1:0]       pdm_data_i,
    output logic             pdm_clk_o,
    pdm_sampler_if.master    stream,
    output logic             overrun_o
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] cnt;
    logic             pdm_clk;
    logic [1:0]       sync1;
    logic [1:0]       s_data;
    logic [1:0]       low_smp;
    logic             have_low;
    logic [3:0]       emit_buf;
    logic [3:0]       frame;
    logic [1:0]       idx;
    logic [1:0]       ch_last;
    logic             overrun;
    logic             tick;
    logic             frame_done;
    logic             load;
    logic             adv;
    logic             ovr_set;
    logic             valid;

`ifdef PDM_SAMPLER_SYNC_EN
    logic [1:0] sync2;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pdm_data_i;
            sync2 <= sync1;
        end
    end

    assign s_data = sync2;
`else
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1 <= '0;
        end else begin
            sync1 <= pdm_data_i;
        end
    end

    assign s_data = sync1;
`endif

    assign tick = cfg_en_i && (cnt == cfg_clkdiv_i);
    // A frame needs a preceding high->low sample; the first high phase after enable has none.
    assign frame_done = tick && !pdm_clk && have_low;
    assign frame      = {s_data[1], low_smp[1], s_data[0], low_smp[0]};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt     <= '0;
            pdm_clk <= 1'b0;
        end else if (!cfg_en_i) begin
            cnt     <= '0;
            pdm_clk <= 1'b0;
        end else if (tick) begin
            cnt     <= '0;
            pdm_clk <= ~pdm_clk;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            low_smp  <= '0;
            have_low <= 1'b0;
        end else if (!cfg_en_i) begin
            low_smp  <= '0;
            have_low <= 1'b0;
        end else if (tick && pdm_clk) begin
            low_smp  <= s_data;
            have_low <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A new frame arriving on the last emission cycle is not an overrun.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        adv       = 1'b0;
        ovr_set   = 1'b0;
        valid     = 1'b0;
        case (state)
            IDLE: begin
                if (frame_done) begin
                    load      = 1'b1;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                valid = 1'b1;
                if (frame_done) begin
                    load    = 1'b1;
                    ovr_set = (idx != ch_last);
                end else if (idx == ch_last) begin
                    state_nxt = IDLE;
                end else begin
                    adv = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!cfg_en_i) begin
            state_nxt = IDLE;
            load      = 1'b0;
            adv       = 1'b0;
            ovr_set   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            emit_buf <= '0;
            idx      <= '0;
            ch_last  <= '0;
        end else if (load) begin
            emit_buf <= frame;
            idx      <= '0;
            ch_last  <= cfg_ch_num_i;
        end else if (adv) begin
            idx <= idx + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            overrun <= 1'b0;
        end else if (!cfg_en_i) begin
            overrun <= 1'b0;
        end else if (ovr_set) begin
            overrun <= 1'b1;
        end
    end

    always_comb begin
        stream.data_valid = valid;
        stream.data       = valid ? emit_buf[idx] : 1'b0;
        stream.ch         = valid ? idx : 2'd0;
    end

    assign pdm_clk_o = pdm_clk;
    assign overrun_o = overrun;

endmodule
